// File: rtl/slover_pkg.sv
// Shared constants and types for the line-by-line nonogram solver.
// SIZE is the default board edge; counts are 7 bits wide everywhere.
package slover_pkg;

  localparam int SIZE  = 3;
  localparam int CNT_W = 7;
  localparam int IDX_W = SIZE;

  localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GET_INDEX = 2'd1,
    GET_OPTS  = 2'd2,
    COMMIT    = 2'd3
  } state_e;

endpackage

// File: rtl/slover_line_merge.sv
// Checks one option against the known/assigned slice of a line (MSB = element 0)
// and produces the next AND/OR accumulator values.
module line_merge import slover_pkg::*; #(
  parameter int SIZE = slover_pkg::SIZE
) (
  input  logic [SIZE-1:0] option,
  input  logic [SIZE-1:0] line_known,
  input  logic [SIZE-1:0] line_asg,
  input  logic [SIZE-1:0] and_acc,
  input  logic [SIZE-1:0] or_acc,
  output logic            consistent,
  output logic [SIZE-1:0] and_nxt,
  output logic [SIZE-1:0] or_nxt
);

  assign consistent = ((option ^ line_asg) & line_known) == '0;
  assign and_nxt    = and_acc & option;
  assign or_nxt     = or_acc | option;

endmodule

// File: rtl/slover.sv
// Streaming line solver: takes a line index followed by its candidate options,
// keeps the options consistent with the board, and commits the forced cells.
module slover import slover_pkg::*; #(
  parameter int SIZE = slover_pkg::SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           started,
  input  logic [SIZE-1:0]                option,
  input  logic                           valid_op,
  input  logic [2*SIZE-1:0][CNT_W-1:0]   old_options_amnt,
  output logic                           put_back_to_FIFO,
  output logic [SIZE-1:0][SIZE-1:0]      assigned,
  output logic [SIZE-1:0][SIZE-1:0]      known,
  output logic [2*SIZE-1:0][CNT_W-1:0]   new_options_amnt,
  output logic                           solved,
  output logic                           error,
  output state_e                         dbg_state
);

  localparam int LINES = 2 * SIZE;

  state_e                        state_q, state_d;
  logic [SIZE-1:0]               idx_q, idx_d;
  logic [SIZE-1:0]               and_q, and_d, or_q, or_d;
  logic [CNT_W-1:0]              rem_q, rem_d, cnt_q, cnt_d;
  logic [SIZE-1:0][SIZE-1:0]     known_q, known_d, asg_q, asg_d;
  logic [LINES-1:0][CNT_W-1:0]   amnt_q, amnt_d;
  logic                          solved_q, solved_d, error_q, error_d;
  logic                          put_back;

  logic [SIZE-1:0]               line_known, line_asg, and_nxt, or_nxt;
  logic                          consistent;
  logic [CNT_W-1:0]              sel_amnt;
  logic                          in_range;

  // Gather the current line's cells, element 0 in the MSB like the option word.
  always_comb begin
    line_known = '0;
    line_asg   = '0;
    for (int k = 0; k < SIZE; k++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (int'(idx_q) == j) begin
          line_known[SIZE-1-k] = known_q[j][k];
          line_asg[SIZE-1-k]   = asg_q[j][k];
        end
        if (int'(idx_q) == SIZE + j) begin
          line_known[SIZE-1-k] = known_q[k][j];
          line_asg[SIZE-1-k]   = asg_q[k][j];
        end
      end
    end
  end

  always_comb begin
    sel_amnt = '0;
    for (int i = 0; i < LINES; i++) begin
      if (int'(option) == i) sel_amnt = old_options_amnt[i];
    end
    in_range = int'(option) < LINES;
  end

  line_merge #(.SIZE(SIZE)) u_merge (
    .option     (option),
    .line_known (line_known),
    .line_asg   (line_asg),
    .and_acc    (and_q),
    .or_acc     (or_q),
    .consistent (consistent),
    .and_nxt    (and_nxt),
    .or_nxt     (or_nxt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    and_d    = and_q;
    or_d     = or_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    known_d  = known_q;
    asg_d    = asg_q;
    amnt_d   = amnt_q;
    error_d  = error_q;
    put_back = 1'b0;

    case (state_q)
      IDLE: begin
        if (started) state_d = GET_INDEX;
      end
      GET_INDEX: begin
        if (valid_op) begin
          idx_d = option;
          rem_d = sel_amnt;
          and_d = '1;
          or_d  = '0;
          cnt_d = '0;
          if (in_range && sel_amnt != '0) state_d = GET_OPTS;
        end
      end
      GET_OPTS: begin
        if (valid_op) begin
          if (consistent) begin
            and_d = and_nxt;
            or_d  = or_nxt;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        put_back = cnt_q > CNT_W'(1);
        state_d  = GET_INDEX;
        if (cnt_q == '0) begin
          error_d = 1'b1;
        end else begin
          // Only unknown cells on this line are touched.
          for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
              if (!known_q[r][c] && int'(idx_q) == r) begin
                if (and_q[SIZE-1-c]) begin
                  known_d[r][c] = 1'b1;
                  asg_d[r][c]   = 1'b1;
                end else if (!or_q[SIZE-1-c]) begin
                  known_d[r][c] = 1'b1;
                  asg_d[r][c]   = 1'b0;
                end
              end
              if (!known_q[r][c] && int'(idx_q) == SIZE + c) begin
                if (and_q[SIZE-1-r]) begin
                  known_d[r][c] = 1'b1;
                  asg_d[r][c]   = 1'b1;
                end else if (!or_q[SIZE-1-r]) begin
                  known_d[r][c] = 1'b1;
                  asg_d[r][c]   = 1'b0;
                end
              end
            end
          end
        end
        for (int i = 0; i < LINES; i++) begin
          if (int'(idx_q) == i) amnt_d[i] = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!started) state_d = IDLE;
    solved_d = &known_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      and_q    <= '0;
      or_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      known_q  <= '0;
      asg_q    <= '0;
      amnt_q   <= '0;
      solved_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      and_q    <= and_d;
      or_q     <= or_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      known_q  <= known_d;
      asg_q    <= asg_d;
      amnt_q   <= amnt_d;
      solved_q <= solved_d;
      error_q  <= error_d;
    end
  end

  assign put_back_to_FIFO = put_back;
  assign assigned         = asg_q;
  assign known            = known_q;
  assign new_options_amnt = amnt_q;
  assign solved           = solved_q;
  assign error            = error_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_slover.sv
// Self-checking bench for slover: directed example board plus randomized lines
// checked against a counting reference model of the line-solving rules.
module tb_slover;

  localparam int SIZE  = 3;
  localparam int LINES = 2 * SIZE;
  localparam int CW    = 7;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          started;
  logic [SIZE-1:0]               option;
  logic                          valid_op;
  logic [LINES-1:0][CW-1:0]      old_amnt;
  logic                          put_back;
  logic [SIZE-1:0][SIZE-1:0]     assigned;
  logic [SIZE-1:0][SIZE-1:0]     known;
  logic [LINES-1:0][CW-1:0]      new_amnt;
  logic                          solved;
  logic                          error;
  slover_pkg::state_e            dbg_state;

  slover #(.SIZE(SIZE)) dut (
    .clk              (clk),
    .rst              (rst),
    .started          (started),
    .option           (option),
    .valid_op         (valid_op),
    .old_options_amnt (old_amnt),
    .put_back_to_FIFO (put_back),
    .assigned         (assigned),
    .known            (known),
    .new_options_amnt (new_amnt),
    .solved           (solved),
    .error            (error),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  // scoreboard: expected put_back value per committed line
  logic [0:0] exp_q[$];

  // reference model of the board
  bit m_known[SIZE][SIZE];
  bit m_val[SIZE][SIZE];
  int m_amnt[LINES];
  bit m_error;
  logic [SIZE-1:0] line_opts[$];
  bit truth[SIZE][SIZE];

  always @(negedge clk) if (put_back) pulse_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cell_r(int idx, int k);
    return (idx < SIZE) ? idx : k;
  endfunction

  function automatic int cell_c(int idx, int k);
    return (idx < SIZE) ? k : idx - SIZE;
  endfunction

  function automatic logic [SIZE*SIZE-1:0] pack_known();
    logic [SIZE*SIZE-1:0] v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) v[r*SIZE+c] = m_known[r][c];
    return v;
  endfunction

  function automatic logic [SIZE*SIZE-1:0] pack_val();
    logic [SIZE*SIZE-1:0] v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) v[r*SIZE+c] = m_known[r][c] & m_val[r][c];
    return v;
  endfunction

  function automatic logic [LINES*CW-1:0] pack_amnt();
    logic [LINES*CW-1:0] v = '0;
    for (int i = 0; i < LINES; i++) v[i*CW +: CW] = CW'(m_amnt[i]);
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        m_known[r][c] = 1'b0;
        m_val[r][c]   = 1'b0;
      end
    for (int i = 0; i < LINES; i++) m_amnt[i] = 0;
    m_error = 1'b0;
    exp_q.delete();
  endtask

  // Count surviving options and, per element, how many of them hold a 1.
  task automatic model_commit(input int idx);
    int cnt = 0;
    int ones[SIZE];
    bit ok;
    logic [SIZE-1:0] w;
    for (int k = 0; k < SIZE; k++) ones[k] = 0;
    foreach (line_opts[i]) begin
      w  = line_opts[i];
      ok = 1'b1;
      for (int k = 0; k < SIZE; k++)
        if (m_known[cell_r(idx, k)][cell_c(idx, k)] && m_val[cell_r(idx, k)][cell_c(idx, k)] != w[SIZE-1-k])
          ok = 1'b0;
      if (ok) begin
        cnt++;
        for (int k = 0; k < SIZE; k++) ones[k] += int'(w[SIZE-1-k]);
      end
    end
    if (cnt == 0) m_error = 1'b1;
    else begin
      for (int k = 0; k < SIZE; k++) begin
        if (!m_known[cell_r(idx, k)][cell_c(idx, k)]) begin
          if (ones[k] == cnt) begin
            m_known[cell_r(idx, k)][cell_c(idx, k)] = 1'b1;
            m_val[cell_r(idx, k)][cell_c(idx, k)]   = 1'b1;
          end else if (ones[k] == 0) begin
            m_known[cell_r(idx, k)][cell_c(idx, k)] = 1'b1;
            m_val[cell_r(idx, k)][cell_c(idx, k)]   = 1'b0;
          end
        end
      end
    end
    m_amnt[idx] = (cnt > 127) ? 127 : cnt;
    exp_q.push_back(cnt > 1);
  endtask

  task automatic check_board(input string tag);
    check_eq({tag, ".known"}, known, pack_known());
    check_eq({tag, ".assigned"}, assigned, pack_val());
    check_eq({tag, ".amnt"}, new_amnt, pack_amnt());
    check_eq({tag, ".error"}, error, m_error);
    check_eq({tag, ".solved"}, solved, &pack_known());
  endtask

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic drive_word(input logic [SIZE-1:0] w);
    option   = w;
    valid_op = 1'b1;
    @(negedge clk);
    valid_op = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    started  = 1'b0;
    valid_op = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic start_solver();
    started = 1'b1;
    @(negedge clk);
    check_eq("start.state", dbg_state, slover_pkg::GET_INDEX);
  endtask

  // old_amnt[idx] must already equal line_opts.size()
  task automatic run_line(input int idx, input bit gaps);
    drive_word(SIZE'(idx));
    foreach (line_opts[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      drive_word(line_opts[i]);
    end
    model_commit(idx);
    check_eq("commit.state", dbg_state, slover_pkg::COMMIT);
    check_eq("commit.put_back", put_back, exp_q.pop_front());
    @(negedge clk);
    check_board("line");
  endtask

  task automatic set_line(input int idx, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [SIZE-1:0] c, input int n);
    line_opts.delete();
    line_opts.push_back(a);
    if (n > 1) line_opts.push_back(b);
    if (n > 2) line_opts.push_back(c);
    old_amnt[idx] = CW'(n);
  endtask

  initial begin
    int idx, n;
    logic [SIZE-1:0] t;

    option   = '0;
    old_amnt = '0;
    do_reset();

    // reset state, then idle
    check_eq("rst.state", dbg_state, slover_pkg::IDLE);
    check_eq("rst.known", known, '0);
    check_eq("rst.assigned", assigned, '0);
    check_eq("rst.amnt", new_amnt, '0);
    check_eq("rst.solved", solved, 1'b0);
    check_eq("rst.error", error, 1'b0);
    check_eq("rst.put_back", put_back, 1'b0);
    option = 3'd0; valid_op = 1'b1;
    repeat (3) @(negedge clk);
    valid_op = 1'b0;
    check_eq("idle.state", dbg_state, slover_pkg::IDLE);
    check_eq("idle.known", known, '0);
    check_eq("idle.put_back", put_back, 1'b0);

    // directed example board
    start_solver();
    pulse_cnt = 0;
    set_line(0, 3'b110, 3'b011, 3'b000, 2); run_line(0, 1'b0);
    check_eq("row0.known", known, 9'b000_000_010);
    check_eq("row0.assigned", assigned, 9'b000_000_010);
    set_line(1, 3'b100, 3'b010, 3'b001, 3); run_line(1, 1'b0);
    set_line(2, 3'b101, 3'b000, 3'b000, 1); run_line(2, 1'b0);
    set_line(3, 3'b101, 3'b000, 3'b000, 1); run_line(3, 1'b0);
    set_line(4, 3'b110, 3'b011, 3'b000, 2); run_line(4, 1'b0);
    check_eq("col1.cells", {known[1][1], assigned[1][1], known[0][1], assigned[0][1]}, 4'b1111);
    check_eq("col1.cnt", new_amnt[4], 7'd1);
    set_line(5, 3'b100, 3'b010, 3'b001, 3); run_line(5, 1'b0);
    check_eq("ex.assigned", assigned, 9'b101_010_011);
    check_eq("ex.known", known, 9'h1FF);
    check_eq("ex.amnt", new_amnt, {7'd1, 7'd1, 7'd1, 7'd1, 7'd3, 7'd2});
    check_eq("ex.solved", solved, 1'b1);
    check_eq("ex.error", error, 1'b0);
    check_eq("ex.pulses", pulse_cnt, 2);

    // all options conflict, then reset in the middle of a line
    do_reset();
    start_solver();
    set_line(0, 3'b111, 3'b000, 3'b000, 1); run_line(0, 1'b0);
    set_line(3, 3'b000, 3'b011, 3'b000, 2); run_line(3, 1'b0);
    check_eq("conf.error", error, 1'b1);
    check_eq("conf.amnt", new_amnt[3], 7'd0);
    check_eq("conf.known", known, 9'b000_000_111);
    old_amnt[0] = 7'd2;
    drive_word(3'd0);
    drive_word(3'b110);
    check_eq("mid.state", dbg_state, slover_pkg::GET_OPTS);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst.state", dbg_state, slover_pkg::IDLE);
    check_eq("midrst.outs", {known, assigned, new_amnt, solved, error, put_back}, '0);
    model_clear();

    // randomized rounds
    for (int round = 0; round < 4; round++) begin
      do_reset();
      start_solver();
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++) truth[r][c] = 1'($urandom_range(0, 1));
      for (int ln = 0; ln < 14; ln++) begin
        idx = $urandom_range(0, LINES - 1);
        case ($urandom_range(0, 9))
          0: begin
            drive_word(SIZE'($urandom_range(LINES, (1 << SIZE) - 1)));
            check_eq("drop.range", dbg_state, slover_pkg::GET_INDEX);
          end
          1: begin
            old_amnt[idx] = '0;
            drive_word(SIZE'(idx));
            check_eq("drop.zero", dbg_state, slover_pkg::GET_INDEX);
          end
          2: begin
            old_amnt[idx] = 7'd3;
            drive_word(SIZE'(idx));
            drive_word(SIZE'($urandom_range(0, 7)));
            started = 1'b0;
            @(negedge clk);
            check_eq("stop.state", dbg_state, slover_pkg::IDLE);
            check_board("stop");
            start_solver();
          end
          default: begin
            for (int k = 0; k < SIZE; k++) t[SIZE-1-k] = truth[cell_r(idx, k)][cell_c(idx, k)];
            n = $urandom_range(1, 4);
            line_opts.delete();
            for (int j = 0; j < n; j++)
              line_opts.push_back(($urandom_range(0, 1) == 1) ? t : SIZE'($urandom_range(0, 7)));
            old_amnt[idx] = CW'(n);
            run_line(idx, 1'b1);
          end
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
